// File: rtl/systolic1x4_ctrl.sv
// Job sequencer for the 1x4 systolic MAC array.
// It clears the array and streams K operand columns with per-lane skew.
// After the array drains, it captures c0..c3 and pulses done.
module systolic1x4_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DW     = 16,
    parameter int AW     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] k_len,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    output logic              busy,
    output logic              done,
    output logic              op_rd_en,
    output logic [ADDR_W-1:0] a_rd_addr,
    output logic [ADDR_W-1:0] b_rd_addr,
    input  logic [4*DW-1:0]   a_rd_data,
    input  logic [DW-1:0]     b_rd_data,
    output logic              arr_rst,
    output logic [DW-1:0]     a0,
    output logic [DW-1:0]     a1,
    output logic [DW-1:0]     a2,
    output logic [DW-1:0]     a3,
    output logic [DW-1:0]     b0,
    input  logic [AW-1:0]     c0,
    input  logic [AW-1:0]     c1,
    input  logic [AW-1:0]     c2,
    input  logic [AW-1:0]     c3,
    output logic [AW-1:0]     res0,
    output logic [AW-1:0]     res1,
    output logic [AW-1:0]     res2,
    output logic [AW-1:0]     res3
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [ADDR_W-1:0] a_base_q, a_base_d;
    logic [ADDR_W-1:0] b_base_q, b_base_d;
    logic [ADDR_W-1:0] j_q, j_d;
    logic [2:0]        drain_q, drain_d;
    logic [AW-1:0]     res_q [4];
    logic [AW-1:0]     res_d [4];

    // Operand pipeline: read-valid, stage 0 capture, then per-lane skew
    logic              vld_p0_q, vld_p0_d;
    logic [DW-1:0]     a_p0_q [4];
    logic [DW-1:0]     a_p0_d [4];
    logic [DW-1:0]     b_p0_q, b_p0_d;
    logic [DW-1:0]     a1_p1_q, a1_p1_d;
    logic [DW-1:0]     a2_p1_q, a2_p1_d;
    logic [DW-1:0]     a2_p2_q, a2_p2_d;
    logic [DW-1:0]     a3_p1_q, a3_p1_d;
    logic [DW-1:0]     a3_p2_q, a3_p2_d;
    logic [DW-1:0]     a3_p3_q, a3_p3_d;

    // Next-state logic, job parameter latching, read addressing and result capture
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        a_base_d  = a_base_q;
        b_base_d  = b_base_q;
        j_d       = j_q;
        drain_d   = drain_q;
        res_d     = res_q;
        op_rd_en  = 1'b0;
        a_rd_addr = '0;
        b_rd_addr = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d      = k_len;
                    a_base_d = a_base;
                    b_base_d = b_base;
                    state_d  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                j_d     = '0;
                drain_d = '0;
                state_d = (k_q == '0) ? S_DRAIN : S_FEED;
            end
            S_FEED: begin
                op_rd_en  = 1'b1;
                a_rd_addr = a_base_q + j_q;
                b_rd_addr = b_base_q + j_q;
                j_d       = j_q + ADDR_W'(1);
                drain_d   = '0;
                if (j_q == k_q - ADDR_W'(1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Five cycles let the last a3 product reach the accumulator
                if (drain_q == 3'd4) begin
                    state_d = S_CAPTURE;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            S_CAPTURE: begin
                res_d[0] = c0;
                res_d[1] = c1;
                res_d[2] = c2;
                res_d[3] = c3;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            j_q      <= '0;
            drain_q  <= '0;
            for (int i = 0; i < 4; i++) res_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            a_base_q <= a_base_d;
            b_base_q <= b_base_d;
            j_q      <= j_d;
            drain_q  <= drain_d;
            for (int i = 0; i < 4; i++) res_q[i] <= res_d[i];
        end
    end

    // Operand skew: invalid read slots are forced to zero so padding adds nothing
    always_comb begin
        vld_p0_d = op_rd_en;
        for (int i = 0; i < 4; i++) begin
            a_p0_d[i] = vld_p0_q ? a_rd_data[i*DW +: DW] : '0;
        end
        b_p0_d  = vld_p0_q ? b_rd_data : '0;
        a1_p1_d = a_p0_q[1];
        a2_p1_d = a_p0_q[2];
        a2_p2_d = a2_p1_q;
        a3_p1_d = a_p0_q[3];
        a3_p2_d = a3_p1_q;
        a3_p3_d = a3_p2_q;
    end

    // Operand pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0_q <= 1'b0;
            for (int i = 0; i < 4; i++) a_p0_q[i] <= '0;
            b_p0_q  <= '0;
            a1_p1_q <= '0;
            a2_p1_q <= '0;
            a2_p2_q <= '0;
            a3_p1_q <= '0;
            a3_p2_q <= '0;
            a3_p3_q <= '0;
        end else begin
            vld_p0_q <= vld_p0_d;
            for (int i = 0; i < 4; i++) a_p0_q[i] <= a_p0_d[i];
            b_p0_q  <= b_p0_d;
            a1_p1_q <= a1_p1_d;
            a2_p1_q <= a2_p1_d;
            a2_p2_q <= a2_p2_d;
            a3_p1_q <= a3_p1_d;
            a3_p2_q <= a3_p2_d;
            a3_p3_q <= a3_p3_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign arr_rst = rst | (state_q == S_CLEAR);
    assign a0      = a_p0_q[0];
    assign a1      = a1_p1_q;
    assign a2      = a2_p2_q;
    assign a3      = a3_p3_q;
    assign b0      = b_p0_q;
    assign res0    = res_q[0];
    assign res1    = res_q[1];
    assign res2    = res_q[2];
    assign res3    = res_q[3];

endmodule

// File: tb/tb_systolic1x4_ctrl.sv
// Bench for systolic1x4_ctrl with an operand-buffer model and a 1x4 array model.
module tb_systolic1x4_ctrl;

    localparam int ADDR_W = 8;
    localparam int DW     = 16;
    localparam int AW     = 32;

    typedef logic [3:0][AW-1:0] exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] k_len = '0, a_base = '0, b_base = '0;
    logic              busy, done, op_rd_en, arr_rst;
    logic [ADDR_W-1:0] a_rd_addr, b_rd_addr;
    logic [4*DW-1:0]   a_rd_data;
    logic [DW-1:0]     b_rd_data;
    logic [DW-1:0]     a0, a1, a2, a3, b0;
    logic [AW-1:0]     c0 = '0, c1 = '0, c2 = '0, c3 = '0;
    logic [AW-1:0]     res0, res1, res2, res3;

    logic [4*DW-1:0]   a_mem [256];
    logic [DW-1:0]     b_mem [256];
    logic [DW-1:0]     bp1 = '0, bp2 = '0, bp3 = '0;

    exp_t sb [$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   done_total = 0;

    int          rd_cnt, rd_first, rd_last, done_cyc, a3_first, a3_last;
    logic [DW-1:0] b0_at [64];
    logic [DW-1:0] a1_at [64];

    systolic1x4_ctrl #(.ADDR_W(ADDR_W), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .a_base(a_base), .b_base(b_base), .busy(busy), .done(done),
        .op_rd_en(op_rd_en), .a_rd_addr(a_rd_addr), .b_rd_addr(b_rd_addr),
        .a_rd_data(a_rd_data), .b_rd_data(b_rd_data), .arr_rst(arr_rst),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3), .b0(b0),
        .c0(c0), .c1(c1), .c2(c2), .c3(c3),
        .res0(res0), .res1(res1), .res2(res2), .res3(res3)
    );

    always #5 clk = ~clk;

    // Operand buffers: one-cycle read latency, junk when not read
    always @(posedge clk) begin
        if (op_rd_en === 1'b1) begin
            a_rd_data <= a_mem[a_rd_addr];
            b_rd_data <= b_mem[b_rd_addr];
        end else begin
            a_rd_data <= {$urandom, $urandom};
            b_rd_data <= DW'($urandom);
        end
    end

    // 1x4 systolic array: b ripples one lane per cycle, each lane accumulates a_i*b_i
    always @(posedge clk) begin
        if (arr_rst !== 1'b0) begin
            c0 <= '0; c1 <= '0; c2 <= '0; c3 <= '0;
            bp1 <= '0; bp2 <= '0; bp3 <= '0;
        end else begin
            c0 <= c0 + AW'(a0) * AW'(b0);
            c1 <= c1 + AW'(a1) * AW'(bp1);
            c2 <= c2 + AW'(a2) * AW'(bp2);
            c3 <= c3 + AW'(a3) * AW'(bp3);
            bp1 <= b0; bp2 <= bp1; bp3 <= bp2;
        end
    end

    always @(negedge clk) if (done === 1'b1) done_total++;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input int k, input int ab, input int bb);
        exp_t e = '0;
        logic [4*DW-1:0] col;
        for (int kk = 0; kk < k; kk++) begin
            col = a_mem[(ab + kk) & 255];
            for (int i = 0; i < 4; i++) begin
                e[i] = e[i] + AW'(col[i*DW +: DW]) * AW'(b_mem[(bb + kk) & 255]);
            end
        end
        return e;
    endfunction

    // Runs one job from the start-sample edge through the DONE cycle, leaving time in the following IDLE cycle
    task automatic run_job(input int k, input int ab, input int bb, input bit poke_feed, input bit poke_done);
        int   n;
        bit   got_done;
        exp_t e;
        sb.push_back(model(k, ab, bb));
        k_len = ADDR_W'(k); a_base = ADDR_W'(ab); b_base = ADDR_W'(bb);
        start = 1'b1;
        step();
        start = 1'b0;
        rd_cnt = 0; rd_first = -1; rd_last = -1; done_cyc = -1; a3_first = -1; a3_last = -1;
        for (int i = 0; i < 64; i++) begin b0_at[i] = '0; a1_at[i] = '0; end
        n = 1; got_done = 0;
        while (!got_done && n <= k + 20) begin
            chk("busy_in_job", busy, 1);
            if (op_rd_en === 1'b1) begin
                chk("a_rd_addr", a_rd_addr, (ab + rd_cnt) & 255);
                chk("b_rd_addr", b_rd_addr, (bb + rd_cnt) & 255);
                rd_cnt++;
                if (rd_first < 0) rd_first = n;
                rd_last = n;
            end
            if (n < 64) begin b0_at[n] = b0; a1_at[n] = a1; end
            if (a3 !== '0) begin
                if (a3_first < 0) a3_first = n;
                a3_last = n;
            end
            if (done === 1'b1) begin
                got_done = 1;
                done_cyc = n;
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 0, 1);
                end else begin
                    e = sb.pop_front();
                    chk("res0", res0, e[0]);
                    chk("res1", res1, e[1]);
                    chk("res2", res2, e[2]);
                    chk("res3", res3, e[3]);
                end
                if (poke_done) start = 1'b1;
            end
            if (poke_feed && n == 2) start = 1'b1;
            step();
            start = 1'b0;
            n++;
        end
        if (!got_done) chk("done_timeout", 0, 1);
        chk("idle_after_done", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin a_mem[i] = '0; b_mem[i] = '0; end

        // Reset state
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", op_rd_en, 0);
        chk("rst_arr_rst", arr_rst, 1);
        chk("rst_b0", b0, 0);
        chk("rst_res0", res0, 0);
        rst = 1'b0;
        step();
        chk("idle_arr_rst", arr_rst, 0);

        // K=1 job
        a_mem[0] = {16'd4, 16'd3, 16'd2, 16'd1};
        b_mem[0] = 16'd5;
        run_job(1, 0, 0, 0, 0);
        chk("k1_rd_cnt", rd_cnt, 1);
        chk("k1_rd_first", rd_first, 2);
        chk("k1_b0_c4", b0_at[4], 5);
        chk("k1_a1_c5", a1_at[5], 2);
        chk("k1_done_cyc", done_cyc, 9);
        chk("k1_res3", res3, 20);

        // Back-to-back: start accepted in the IDLE cycle right after DONE
        b_mem[0] = 16'd1;
        run_job(1, 0, 0, 0, 0);
        chk("b2b_done_cyc", done_cyc, 9);
        chk("b2b_res1", res1, 2);

        // K=3 with wrapping A address, start pokes in FEED and DONE
        for (int kk = 0; kk < 3; kk++) begin
            a_mem[(254 + kk) & 255] = {16'd4, 16'd3, 16'd2, 16'd1};
            b_mem[10 + kk] = DW'(kk + 1);
        end
        run_job(3, 254, 10, 1, 1);
        chk("k3_rd_cnt", rd_cnt, 3);
        chk("k3_rd_last", rd_last, 4);
        chk("k3_done_cyc", done_cyc, 11);
        chk("k3_a3_first", a3_first, 7);
        chk("k3_a3_last", a3_last, 9);
        chk("k3_res0", res0, 6);
        chk("k3_res3", res3, 24);
        step(); step(); step();
        chk("k3_no_requeue", busy, 0);
        chk("k3_done_total", done_total, 3);

        // K=0 job
        run_job(0, 5, 5, 0, 0);
        chk("k0_rd_cnt", rd_cnt, 0);
        chk("k0_done_cyc", done_cyc, 8);
        chk("k0_res0", res0, 0);

        // Reset during the second FEED cycle of a K=3 job
        k_len = 8'd3; a_base = 8'd0; b_base = 8'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("abort_in_feed", op_rd_en, 1);
        rst = 1'b1;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_rd_en", op_rd_en, 0);
        chk("abort_arr_rst", arr_rst, 1);
        chk("abort_a0", a0, 0);
        chk("abort_b0", b0, 0);
        chk("abort_res0", res0, 0);
        rst = 1'b0;
        for (int i = 0; i < 14; i++) step();
        chk("abort_no_done", done_total, 4);
        chk("abort_idle", busy, 0);

        // Fresh K=1 job after abort
        b_mem[0] = 16'd7;
        run_job(1, 0, 0, 0, 0);
        chk("post_done_cyc", done_cyc, 9);
        chk("post_res2", res2, 21);
        step();
        chk("sb_drained", sb.size(), 0);
        chk("done_total", done_total, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
